// File: rtl/mcu_pkg.sv
// Shared constants for the MCU SPI slave: target ids, FSM state codes, default MISO sync byte.
// Also holds the target decode helper.
package mcu_pkg;

  localparam logic [7:0] TGT_SYS  = 8'd0;
  localparam logic [7:0] TGT_HID  = 8'd1;
  localparam logic [7:0] TGT_OSD  = 8'd2;
  localparam logic [7:0] TGT_SDC  = 8'd3;
  localparam logic [7:0] TGT_NONE = 8'hff;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h5c;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_TARGET  = 2'd1;
  localparam state_t ST_COMMAND = 2'd2;
  localparam state_t ST_PAYLOAD = 2'd3;

  // Strobe vector is {sdc, osd, hid, sys}; unknown ids select nobody.
  function automatic logic [3:0] tgt_onehot(input logic [7:0] tgt);
    logic [3:0] oh;
    oh = 4'b0000;
    case (tgt)
      TGT_SYS: oh = 4'b0001;
      TGT_HID: oh = 4'b0010;
      TGT_OSD: oh = 4'b0100;
      TGT_SDC: oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mcu_spi_slave_if.sv
// Pin and target-side bundle of the MCU SPI slave.
// The slave modport is the FPGA side; master is the MCU plus message consumers.
interface mcu_spi_slave_if;

  logic       spi_csn;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;

  logic [7:0] data_in;
  logic       data_in_start;
  logic       sys_strobe;
  logic       hid_strobe;
  logic       osd_strobe;
  logic       sdc_strobe;

  logic [7:0] sys_dout;
  logic [7:0] hid_dout;
  logic [7:0] osd_dout;
  logic [7:0] sdc_dout;

  modport slave (
    input  spi_csn,
    input  spi_sclk,
    input  spi_mosi,
    input  sys_dout,
    input  hid_dout,
    input  osd_dout,
    input  sdc_dout,
    output spi_miso,
    output data_in,
    output data_in_start,
    output sys_strobe,
    output hid_strobe,
    output osd_strobe,
    output sdc_strobe
  );

  modport master (
    output spi_csn,
    output spi_sclk,
    output spi_mosi,
    output sys_dout,
    output hid_dout,
    output osd_dout,
    output sdc_dout,
    input  spi_miso,
    input  data_in,
    input  data_in_start,
    input  sys_strobe,
    input  hid_strobe,
    input  osd_strobe,
    input  sdc_strobe
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with optional rise/fall detection
// taken from the last two synchronised samples. Stages is legal from 2 to 3.
module spi_sync_edge #(
  parameter int unsigned Stages     = 2,
  parameter logic        ResetVal   = 1'b0,
  parameter bit          EdgeDetect = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {Stages{ResetVal}};
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

  if (EdgeDetect) begin : g_edge
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        prev_q <= ResetVal;
      end else begin
        prev_q <= sync_q[Stages-1];
      end
    end

    assign rise_o = sync_q[Stages-1] & ~prev_q;
    assign fall_o = ~sync_q[Stages-1] & prev_q;
  end else begin : g_plain
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
  end

endmodule

// File: rtl/mcu_spi_slave.sv
// Oversampled mode-0 SPI slave: first byte of a frame selects a target, later bytes are
// strobed to it, and the target's reply is shifted back on MISO one byte late.
module mcu_spi_slave
  import mcu_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  mcu_spi_slave_if.slave  bus
);

  logic csn_s, sclk_s, mosi_s;
  logic sclk_rise, sclk_fall;
  logic csn_rise_unused, csn_fall_unused, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(
    .Stages     (SYNC_STAGES),
    .ResetVal   (1'b1),
    .EdgeDetect (1'b0)
  ) u_sync_csn (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (bus.spi_csn),
    .q_o    (csn_s),
    .rise_o (csn_rise_unused),
    .fall_o (csn_fall_unused)
  );

  spi_sync_edge #(
    .Stages     (SYNC_STAGES),
    .ResetVal   (1'b0),
    .EdgeDetect (1'b1)
  ) u_sync_sclk (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (bus.spi_sclk),
    .q_o    (sclk_s),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge #(
    .Stages     (SYNC_STAGES),
    .ResetVal   (1'b0),
    .EdgeDetect (1'b0)
  ) u_sync_mosi (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (bus.spi_mosi),
    .q_o    (mosi_s),
    .rise_o (mosi_rise_unused),
    .fall_o (mosi_fall_unused)
  );

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] target_q, target_d;
  logic [7:0] data_in_q, data_in_d;
  logic       start_q, start_d;
  logic [3:0] strobe_q, strobe_d;
  logic [6:0] tx_sr_q, tx_sr_d;
  logic       miso_q, miso_d;
  logic       reload_q, reload_d;

  logic       active;
  logic       byte_done;
  logic [7:0] rx_byte;
  logic [7:0] dout_sel;

  assign active    = (state_q != ST_IDLE);
  assign byte_done = active && sclk_rise && (bit_cnt_q == 3'd7);
  assign rx_byte   = {shift_q, mosi_s};

  always_comb begin
    dout_sel = 8'h00;
    case (target_q)
      TGT_SYS: dout_sel = bus.sys_dout;
      TGT_HID: dout_sel = bus.hid_dout;
      TGT_OSD: dout_sel = bus.osd_dout;
      TGT_SDC: dout_sel = bus.sdc_dout;
      default: dout_sel = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    target_d  = target_q;
    data_in_d = data_in_q;
    start_d   = start_q;
    strobe_d  = 4'b0000;
    tx_sr_d   = tx_sr_q;
    miso_d    = miso_q;
    reload_d  = (|strobe_q) && active && !csn_s;

    if (active && sclk_rise) begin
      shift_d   = rx_byte[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    // The fall that trails the 8th rise (count already wrapped) must not shift, or the
    // freshly reloaded reply would lose its MSB.
    if (active && sclk_fall && (bit_cnt_q != 3'd0)) begin
      miso_d  = tx_sr_q[6];
      tx_sr_d = {tx_sr_q[5:0], 1'b0};
    end

    if (reload_q && active) begin
      miso_d  = dout_sel[7];
      tx_sr_d = dout_sel[6:0];
    end

    case (state_q)
      ST_IDLE: begin
        if (!csn_s) begin
          state_d   = ST_TARGET;
          bit_cnt_d = 3'd0;
          miso_d    = SYNC_BYTE[7];
          tx_sr_d   = SYNC_BYTE[6:0];
        end
      end
      ST_TARGET: begin
        if (byte_done) begin
          target_d = rx_byte;
          miso_d   = 1'b0;
          tx_sr_d  = 7'd0;
          state_d  = ST_COMMAND;
        end
      end
      ST_COMMAND: begin
        if (byte_done) begin
          data_in_d = rx_byte;
          start_d   = 1'b1;
          strobe_d  = tgt_onehot(target_q);
          state_d   = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (byte_done) begin
          data_in_d = rx_byte;
          start_d   = 1'b0;
          strobe_d  = tgt_onehot(target_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Deselect wins over everything except a byte that completes in the same clk.
    if (active && csn_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b0;
      reload_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 7'd0;
      target_q  <= TGT_NONE;
      data_in_q <= 8'h00;
      start_q   <= 1'b0;
      strobe_q  <= 4'b0000;
      tx_sr_q   <= 7'd0;
      miso_q    <= 1'b0;
      reload_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      target_q  <= target_d;
      data_in_q <= data_in_d;
      start_q   <= start_d;
      strobe_q  <= strobe_d;
      tx_sr_q   <= tx_sr_d;
      miso_q    <= miso_d;
      reload_q  <= reload_d;
    end
  end

  assign bus.spi_miso      = miso_q;
  assign bus.data_in       = data_in_q;
  assign bus.data_in_start = start_q;
  assign bus.sys_strobe    = strobe_q[0];
  assign bus.hid_strobe    = strobe_q[1];
  assign bus.osd_strobe    = strobe_q[2];
  assign bus.sdc_strobe    = strobe_q[3];

endmodule

// File: tb/tb_mcu_spi_slave.sv
// Directed bench for mcu_spi_slave: table of SPI frames with expected strobes and MISO bytes,
// plus hand-written abort and mid-payload reset sequences.
module tb_mcu_spi_slave;

  localparam int HALF = 80;  // half sclk period; clk is 10 ns so sclk = clk/16

  typedef struct {
    logic [31:0] bytes;     // byte 0 in [31:24]
    int          nbytes;
    int          tgt;       // 0..3, or -1 for an unknown target
    logic [31:0] miso;      // expected MISO per byte, byte 0 in [31:24]
    logic [3:0]  miso_chk;  // bit b enables the MISO check of byte b
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  mcu_spi_slave_if ifc ();

  mcu_spi_slave #(
    .SYNC_STAGES (2),
    .SYNC_BYTE   (8'h5c)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_checks = 0;

  logic [3:0] rec_tgt   [64];
  logic [7:0] rec_data  [64];
  logic       rec_start [64];
  int         rec_n = 0;
  int         onehot_viol = 0;

  // Strobe monitor, sampled on the falling clk edge.
  initial begin : mon
    logic [3:0] s;
    forever begin
      @(negedge clk);
      s = {ifc.sdc_strobe, ifc.osd_strobe, ifc.hid_strobe, ifc.sys_strobe};
      if (s != 4'b0000) begin
        if ($countones(s) > 1) onehot_viol++;
        if (rec_n < 64) begin
          rec_tgt[rec_n]   = s;
          rec_data[rec_n]  = ifc.data_in;
          rec_start[rec_n] = ifc.data_in_start;
        end
        rec_n++;
      end
    end
  end

  // SDC target model: registers a new reply byte on each of its strobes.
  logic [7:0] sdc_reply [3];
  int sdc_idx = 0;
  initial begin : sdc_model
    sdc_reply[0] = 8'ha1;
    sdc_reply[1] = 8'hb2;
    sdc_reply[2] = 8'hc3;
    ifc.sdc_dout = 8'h00;
    forever begin
      @(negedge clk);
      if (ifc.sdc_strobe) begin
        ifc.sdc_dout = sdc_reply[sdc_idx % 3];
        sdc_idx++;
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      ifc.spi_mosi = tx[7-i];
      #HALF;
      rx = {rx[6:0], ifc.spi_miso};
      ifc.spi_sclk = 1'b1;
      #HALF;
      ifc.spi_sclk = 1'b0;
    end
  endtask

  task automatic frame_begin();
    @(negedge clk);
    ifc.spi_csn = 1'b0;
    #HALF;
  endtask

  task automatic frame_end();
    #HALF;
    ifc.spi_csn = 1'b1;
    #(4 * HALF);
  endtask

  function automatic vec_t mk(input logic [31:0] bytes, input int nbytes, input int tgt,
                              input logic [31:0] miso, input logic [3:0] chk,
                              input string name);
    vec_t v;
    v.bytes    = bytes;
    v.nbytes   = nbytes;
    v.tgt      = tgt;
    v.miso     = miso;
    v.miso_chk = chk;
    v.name     = name;
    return v;
  endfunction

  task automatic run_vector(input vec_t v);
    int base, got, exp_n;
    logic [7:0] rx;
    base = rec_n;
    frame_begin();
    for (int b = 0; b < v.nbytes; b++) begin
      spi_xfer(v.bytes[31-8*b -: 8], 8, rx);
      if (v.miso_chk[b]) check($sformatf("%s miso byte%0d", v.name, b), rx, v.miso[31-8*b -: 8]);
    end
    frame_end();
    check($sformatf("%s idle miso", v.name), ifc.spi_miso, 0);
    got   = rec_n - base;
    exp_n = (v.tgt >= 0) ? v.nbytes - 1 : 0;
    check($sformatf("%s strobe count", v.name), got, exp_n);
    for (int k = 0; k < exp_n && k < got; k++) begin
      check($sformatf("%s strobe%0d target", v.name, k), rec_tgt[base+k], 4'b0001 << v.tgt);
      check($sformatf("%s strobe%0d data_in", v.name, k), rec_data[base+k],
            v.bytes[31-8*(k+1) -: 8]);
      check($sformatf("%s strobe%0d start", v.name, k), rec_start[base+k], (k == 0));
    end
  endtask

  vec_t vecs [4];

  initial begin : main
    int base;
    logic [7:0] rx;

    vecs[0] = mk(32'h0101_8400, 3,  1, 32'h5c00_0100, 4'b0111, "hid");
    vecs[1] = mk(32'h0305_aa55, 4,  3, 32'h5c00_a1b2, 4'b1111, "sdc");
    vecs[2] = mk(32'h0701_0200, 3, -1, 32'h5c00_0000, 4'b0111, "none");
    vecs[3] = mk(32'h003c_0000, 2,  0, 32'h5c00_0000, 4'b0011, "sys");

    ifc.spi_csn  = 1'b1;
    ifc.spi_sclk = 1'b0;
    ifc.spi_mosi = 1'b0;
    ifc.sys_dout = 8'h80;
    ifc.hid_dout = 8'h01;
    ifc.osd_dout = 8'h7e;

    #2;
    check("reset data_in", ifc.data_in, 8'h00);
    check("reset flags", {ifc.spi_miso, ifc.data_in_start, ifc.sys_strobe, ifc.hid_strobe,
                          ifc.osd_strobe, ifc.sdc_strobe}, 6'b0);
    #21;
    reset_n = 1'b1;
    #40;

    for (int i = 0; i < 4; i++) run_vector(vecs[i]);

    // Abort the command byte after 4 bits, then a clean frame must decode from scratch.
    base = rec_n;
    frame_begin();
    spi_xfer(8'h01, 8, rx);
    spi_xfer(8'ha5, 4, rx);
    #HALF;
    ifc.spi_csn = 1'b1;
    #(4 * HALF);
    check("abort strobe count", rec_n - base, 0);
    check("abort miso", ifc.spi_miso, 0);
    run_vector(mk(32'h0100_0000, 2, 1, 32'h5c00_0000, 4'b0011, "post-abort"));

    // Reset mid-payload while csn stays low.
    base = rec_n;
    frame_begin();
    spi_xfer(8'h00, 8, rx);
    spi_xfer(8'h11, 8, rx);
    spi_xfer(8'h22, 8, rx);
    #HALF;
    check("pre-reset strobe count", rec_n - base, 2);
    check("pre-reset data_in", ifc.data_in, 8'h22);
    check("pre-reset miso reload", ifc.spi_miso, 1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid reset data_in", ifc.data_in, 8'h00);
    check("mid reset flags", {ifc.spi_miso, ifc.data_in_start, ifc.sys_strobe, ifc.hid_strobe,
                              ifc.osd_strobe, ifc.sdc_strobe}, 6'b0);
    #20;
    reset_n = 1'b1;
    #HALF;
    base = rec_n;
    spi_xfer(8'h02, 8, rx);
    check("post-reset miso byte0", rx, 8'h5c);
    spi_xfer(8'h33, 8, rx);
    frame_end();
    check("post-reset strobe count", rec_n - base, 1);
    if (rec_n - base >= 1) begin
      check("post-reset target", rec_tgt[base], 4'b0100);
      check("post-reset data_in", rec_data[base], 8'h33);
      check("post-reset start", rec_start[base], 1);
    end

    check("single strobe per clk", onehot_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mcu_spi_slave.md
Name: mcu_spi_slave

Overview:
- SPI slave between the IO MCU and the FPGA message consumers (sys, hid, osd, sdc).
- Oversamples the MCU SPI pins in the system clock domain and deserialises MOSI into bytes.
- Routes each frame to one target selected by the frame's first byte and generates the byte strobe and start flags those targets consume.
- Returns the selected target's reply byte on MISO during the following byte.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on spi_sclk/spi_csn/spi_mosi; legal 2..3.
- SYNC_BYTE, 8'h5c, MISO reply shifted out during the target byte of every frame.

Ports:
- clk  in  1  system clock; must be >= 8x spi_sclk frequency.
- reset_n  in  1  asynchronous active-low reset.
- spi_csn  in  1  MCU chip select, active low.
- spi_sclk  in  1  MCU SPI clock, mode 0.
- spi_mosi  in  1  MCU to FPGA data, MSB first.
- spi_miso  out  1  FPGA to MCU data, MSB first.
- data_in  out  8  last received byte; shared by all targets.
- data_in_start  out  1  qualifies strobe: byte is the command byte (second byte of frame).
- sys_strobe  out  1  one-clk byte strobe, target 0.
- hid_strobe  out  1  one-clk byte strobe, target 1.
- osd_strobe  out  1  one-clk byte strobe, target 2.
- sdc_strobe  out  1  one-clk byte strobe, target 3.
- sys_dout, hid_dout, osd_dout, sdc_dout  in  8 each  target reply bytes.

Behaviour:
- Reset (async, reset_n=0) values:
  - all strobes 0, data_in 8'h00, data_in_start 0, spi_miso 0.
  - bit_cnt 0, target 8'hff (none), state IDLE.
  - synchroniser flops are set to csn=1, sclk=0, mosi=0.
- Synchronisation and edge detection:
  - Each pin passes through SYNC_STAGES flops.
  - sclk_rise and sclk_fall are detected from the last two synchronised sclk samples.
- FSM states: IDLE, TARGET, COMMAND, PAYLOAD.
  - IDLE -> TARGET when the synchronised csn is low.
  - Synchronised csn high in any state -> IDLE within 1 clk.
    - Clears bit_cnt, aborts any partial byte without a strobe, and drives spi_miso 0.
    - target is held until the next frame.
  - TARGET: on byte completion, target <= byte; no strobe; -> COMMAND.
  - COMMAND: on byte completion, data_in <= byte, data_in_start=1, and the selected target's strobe pulses 1 clk; -> PAYLOAD.
  - PAYLOAD: each completed byte sets data_in <= byte, data_in_start=0, and pulses the selected target's strobe; stays in PAYLOAD; there is no byte limit.
- Bit reception:
  - On sclk_rise, shift_in <= {shift_in[6:0], mosi_sync} and bit_cnt increments modulo 8.
  - Byte completion is the rise where bit_cnt==7.
  - data_in, data_in_start and the strobe are registered and valid in the same clk; latency is 1 clk after the synchronised 8th rising edge.
- Target decode:
  - Byte 0..3 selects sys, hid, osd, sdc.
  - Any other value: no strobe for the rest of the frame; MISO replies 8'h00.
- MISO:
  - On entry to TARGET, tx_sr <= SYNC_BYTE and spi_miso <= SYNC_BYTE[7].
  - Every sclk_fall shifts tx_sr left and drives spi_miso <= the new tx_sr[7].
  - Exactly 2 clk after each strobe (targets register dout on strobe), tx_sr <= selected dout and spi_miso <= dout[7].
    - This reload happens before the next byte's first sclk_fall, which the 8x ratio guarantees.
  - The reply to byte N therefore appears during byte N+1.
  - After the target byte, the first reload loads the selected dout; the MCU discards that byte.
- Simultaneous events:
  - csn deassert in the same clk as byte completion: the completion is honoured (strobe issued), then the FSM goes to IDLE.
  - A reload pending at csn rise is cancelled.
- Only one strobe is ever high in a given clk.

Decomposition:
- Shared package mcu_pkg:
  - target id constants TGT_SYS=0, TGT_HID=1, TGT_OSD=2, TGT_SDC=3.
  - FSM state enum.
  - SYNC_BYTE default.
- One sub-module, spi_sync_edge: parameterised synchroniser with rise/fall detection for sclk; csn and mosi use its plain-sync variant.

Test Plan:
- Frame {01, 01, 84} at clk=16x sclk:
  - hid_strobe pulses twice.
  - First pulse: data_in=01, data_in_start=1.
  - Second pulse: data_in=84, data_in_start=0.
  - sys/osd/sdc strobes stay 0.
- Target byte: MISO shifts 0x5c. hid_dout=0x01 after the command byte: MISO during byte 3 reads 0x01.
- Frame {03, 05, AA, 55}:
  - sdc_strobe pulses 3 times with data_in 05, AA, 55.
  - sdc_dout values are echoed on MISO, each one byte late.
- Frame {07, 01, 02}: no strobes; MISO reads 5c, 00, 00.
- csn raised after 4 bits of the command byte:
  - no strobe; FSM returns to IDLE.
  - a following frame {01, 00} yields a hid_strobe with data_in=00 and data_in_start=1.
- Assert reset_n=0 mid-payload: all outputs return to their reset values immediately; the first byte after release is treated as a target byte.
